div_iter: RTL and testbench

- Iterative radix-2 restoring divider. It is the responder for the ALU's division handshake (start_div, signed_div, div_result, div_ready).
- Sits beside the ALU in EX and serves DIV/DIVU.
- The ALU holds start while ready is low and stalls the pipeline. The divider returns {remainder, quotient} in HI/LO order with a one-cycle-visible ready.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_if.sv | 26 ++
 rtl/div_step.sv | 26 ++
 rtl/div_iter.sv | 141 ++++++++++++++
 tb/tb_div_iter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
// Optional early termination is enabled by defining DIV_EARLY_TERM_EN.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_WIDTH-1:0]   ZeroWord  = '0;
  localparam logic [2*DIV_WIDTH-1:0] ZeroDword = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_if.sv
// ALU <-> divider handshake: the ALU is the master, the divider the slave.
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_ge;

  // The shifted remainder can reach 2*divisor-1, so one extra bit keeps the trial sign exact.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign w_ge    = ~w_trial[WIDTH];

  assign o_rem = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider answering the ALU DIV/DIVU handshake.
// Define DIV_EARLY_TERM_EN to short-cut operations where |dividend| < |divisor|.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic clk,
  input  logic resetn,
  div_if.slave bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  div_state_t         r_state;
  div_state_t         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic               w_neg1;
  logic               w_neg2;
  logic               w_short;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic [WIDTH-1:0]   w_fix_rem;
  logic [WIDTH-1:0]   w_fix_quo;

  assign w_neg1 = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign w_neg2 = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign w_abs1 = w_neg1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_abs2 = w_neg2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

`ifdef DIV_EARLY_TERM_EN
  assign w_short = (w_abs1 < w_abs2);
`else
  assign w_short = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  assign w_fix_quo = r_neg_q ? (~w_step_quo + 1'b1) : w_step_quo;
  assign w_fix_rem = r_neg_r ? (~w_step_rem + 1'b1) : w_step_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Short-cut results reuse the one-cycle BYZERO path so ready lands in cycle 2.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0 || w_short) w_state_next = BYZERO;
          else                                w_state_next = ON;
        end
      end
      BYZERO:  w_state_next = bus.annul_i ? IDLE : END;
      ON: begin
        if (bus.annul_i)         w_state_next = IDLE;
        else if (r_cnt == LastCnt) w_state_next = END;
      end
      END: begin
        if (bus.annul_i || !bus.start_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (w_state_next == ON) begin
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_divisor <= w_abs2;
            r_cnt     <= '0;
            r_neg_q   <= w_neg1 ^ w_neg2;
            r_neg_r   <= w_neg1;
          end else if (w_state_next == BYZERO) begin
            // Divide-by-zero yields 0; a short-cut keeps the original signed dividend as remainder.
            r_rem <= (bus.opdata2_i == '0) ? '0 : bus.opdata1_i;
            r_quo <= '0;
          end
        end
        BYZERO: begin
          if (w_state_next == END) begin
            r_result <= {r_rem, r_quo};
            r_ready  <= 1'b1;
          end
        end
        ON: begin
          if (w_state_next != IDLE) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_state_next == END) begin
            r_result <= {w_fix_rem, w_fix_quo};
            r_ready  <= 1'b1;
          end
        end
        END: begin
          if (w_state_next == IDLE) r_ready <= 1'b0;
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: vector table plus annul/reset sequences.
module tb_div_iter;
  import div_pkg::*;

`ifdef DIV_EARLY_TERM_EN
  localparam int EL = 2;
`else
  localparam int EL = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  vec_t vecs[12];

  div_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string name);
    int   cyc;
    logic got;
    @(negedge clk);
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.signed_i  = ~sgn;
      end
      if (bus.ready_o) got = 1'b1;
    end
    $display("TXN %s sgn=%0d a=%h b=%h lat=%0d result=%h", name, sgn, a, b, cyc, bus.result_o);
    chk({name, "_seen"}, 64'(got), 64'd1);
    chk({name, "_lat"}, 64'(cyc), 64'(lat));
    chk({name, "_res"}, bus.result_o, exp);
    @(posedge clk);
    #1;
    chk({name, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
    chk({name, "_hold_res"}, bus.result_o, exp);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
    chk({name, "_idle_res"}, bus.result_o, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, "u100_7"};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, "s-7_2"};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, "s7_-2"};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          ZeroDword,             2,  "u5_0"};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, "s_ovf"};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, "umax_1"};
    vecs[6]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 33, "u9_3"};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, EL, "u3_10"};
    vecs[8]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         64'hFFFFFFFD_00000000, EL, "s-3_10"};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33, "umax_umax"};
    vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33, "s-100_-7"};
    vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, EL, "u_big_small"};

    resetn        = 1'b0;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = ZeroWord;
    bus.opdata2_i = ZeroWord;
    bus.annul_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, ZeroDword);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++)
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // annul at iteration 10 of 100/7: no ready, result keeps the previous value
    begin
      logic [63:0] prev;
      logic        seen;
      prev = bus.result_o;
      seen = 1'b0;
      @(negedge clk);
      bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.start_i = 1'b1;
      repeat (11) begin @(posedge clk); #1; if (bus.ready_o) seen = 1'b1; end
      @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (bus.ready_o) seen = 1'b1; end
      $display("TXN annul_on seen_ready=%0d result=%h", seen, bus.result_o);
      chk("annul_on_ready", 64'(seen), 64'd0);
      chk("annul_on_result", bus.result_o, prev);
    end
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, "after_annul_9_3");

    // annul while start is held in IDLE blocks the request
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      bus.opdata1_i = 32'd8; bus.opdata2_i = 32'd0; bus.start_i = 1'b1; bus.annul_i = 1'b1;
      repeat (4) begin @(posedge clk); #1; if (bus.ready_o) seen = 1'b1; end
      @(negedge clk);
      bus.start_i = 1'b0; bus.annul_i = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (bus.ready_o) seen = 1'b1; end
      $display("TXN annul_idle seen_ready=%0d", seen);
      chk("annul_idle_ready", 64'(seen), 64'd0);
    end

    // annul in END with start still high drops ready next cycle
    begin
      int cyc;
      @(negedge clk);
      bus.signed_i = 1'b0; bus.opdata1_i = 32'd6; bus.opdata2_i = 32'd0; bus.start_i = 1'b1;
      cyc = 0;
      while (!bus.ready_o && cyc < 10) begin @(posedge clk); #1; cyc++; end
      chk("annul_end_lat", 64'(cyc), 64'd2);
      @(negedge clk);
      bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      $display("TXN annul_end ready=%0d", bus.ready_o);
      chk("annul_end_ready", 64'(bus.ready_o), 64'd0);
      @(negedge clk);
      bus.annul_i = 1'b0; bus.start_i = 1'b0;
    end

    // async reset at iteration 20 clears outputs at once
    @(negedge clk);
    bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    $display("TXN reset_mid ready=%0d result=%h", bus.ready_o, bus.result_o);
    chk("rst_mid_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_mid_result", bus.result_o, ZeroDword);
    @(negedge clk);
    bus.start_i = 1'b0;
    resetn = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "after_rst_100_7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
